// File: rtl/ff_bank_pkg.sv
// Shared mode encoding for the ff_bank flip-flop bank.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

endpackage

// File: rtl/ff_cell.sv
// One flip-flop channel: next-state function and SR illegal-input flag.
module ff_cell
  import ff_bank_pkg::*;
(
  input  logic  qn,
  input  logic  s,
  input  logic  r,
  input  mode_t mode,
  input  logic  en,
  output logic  q_next,
  output logic  viol
);

  always_comb begin
    q_next = qn;
    viol   = 1'b0;
    if (en) begin
      unique case (mode)
        MODE_SR: begin
          if (s && !r)      q_next = 1'b1;
          else if (!s && r) q_next = 1'b0;
          viol = s & r;
        end
        MODE_JK: begin
          if (s && r)       q_next = ~qn;
          else if (s)       q_next = 1'b1;
          else if (r)       q_next = 1'b0;
        end
        MODE_D:  q_next = s;
        MODE_T:  q_next = s ? ~qn : qn;
        default: q_next = qn;
      endcase
    end
  end

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH mode-selectable flip-flops with sticky violation mask and saturating counter.
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  INIT  = '0,
  parameter int unsigned       CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  output logic [CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] viol;
  logic [WIDTH-1:0] mask_reg;
  logic [CNT_W-1:0] cnt_reg;
  mode_t            mode_sel;

  assign mode_sel = mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .qn     (q_reg[i]),
      .s      (s[i]),
      .r      (r[i]),
      .mode   (mode_sel),
      .en     (en),
      .q_next (q_next[i]),
      .viol   (viol[i])
    );
  end

  // viol is already gated by en, so the error state needs no separate enable
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg    <= INIT;
      mask_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      if (en) q_reg <= q_next;
      if (clr_err) begin
        mask_reg <= viol;
        cnt_reg  <= (|viol) ? CNT_W'(1) : '0;
      end else begin
        mask_reg <= mask_reg | viol;
        if ((|viol) && (cnt_reg != '1)) cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign q        = q_reg;
  assign qbar     = ~q_reg;
  assign err_mask = mask_reg;
  assign err      = |mask_reg;
  assign err_cnt  = cnt_reg;

endmodule

// File: tb/tb_ff_bank.sv
// Directed self-checking bench for ff_bank (INIT=8'hA5, CNT_W=2).
module tb_ff_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst, en, clr_err;
  logic [1:0]       mode;
  logic [WIDTH-1:0] s, r;
  logic [WIDTH-1:0] q, qbar, err_mask;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ff_bank #(.WIDTH(WIDTH), .INIT(8'hA5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .clr_err(clr_err),
    .q(q), .qbar(qbar), .err(err), .err_mask(err_mask), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b11; s = 8'hFF; r = 8'hFF; clr_err = 1'b0;
    step();
    n_cmp++; if (q !== 8'hA5) begin n_bad++; $display("FAIL reset_q: got %h want a5", q); end
    n_cmp++; if (qbar !== 8'h5A) begin n_bad++; $display("FAIL reset_qbar: got %h want 5a", qbar); end
    n_cmp++; if (err_mask !== 8'h00) begin n_bad++; $display("FAIL reset_mask: got %h want 00", err_mask); end
    n_cmp++; if (err_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0; en = 1'b0; mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (q !== 8'hA5) begin n_bad++; $display("FAIL hold_en0 cyc%0d: got %h want a5", i, q); end
      n_cmp++; if (err_mask !== 8'h00) begin n_bad++; $display("FAIL hold_en0_mask cyc%0d: got %h want 00", i, err_mask); end
    end
  endtask

  task automatic test_sr();
    logic [WIDTH-1:0] sv [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
    logic [WIDTH-1:0] rv [4] = '{8'h00, 8'h00, 8'h01, 8'h00};
    logic [WIDTH-1:0] eq [4] = '{8'hA5, 8'hA5, 8'hA4, 8'hA4};
    en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      s = sv[i]; r = rv[i];
      step();
      n_cmp++; if (q !== eq[i]) begin n_bad++; $display("FAIL sr_sweep%0d: got %h want %h", i, q, eq[i]); end
    end
    n_cmp++; if (err_cnt !== 2'd0) begin n_bad++; $display("FAIL sr_no_viol_cnt: got %0d want 0", err_cnt); end
    s = 8'h01; r = 8'h01;
    step();
    n_cmp++; if (q !== 8'hA4) begin n_bad++; $display("FAIL sr_illegal_q: got %h want a4", q); end
    n_cmp++; if (err_mask !== 8'h01) begin n_bad++; $display("FAIL sr_illegal_mask: got %h want 01", err_mask); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL sr_illegal_err: got %b want 1", err); end
    n_cmp++; if (err_cnt !== 2'd1) begin n_bad++; $display("FAIL sr_illegal_cnt: got %0d want 1", err_cnt); end
  endtask

  task automatic test_jk_t();
    logic [WIDTH-1:0] ejk [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [WIDTH-1:0] et  [3] = '{8'h0F, 8'h00, 8'h0F};
    mode = 2'b10; s = 8'h00; r = 8'h00;
    step();
    n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL d_clear: got %h want 00", q); end
    mode = 2'b01; s = 8'hFF; r = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (q !== ejk[i]) begin n_bad++; $display("FAIL jk_toggle%0d: got %h want %h", i, q, ejk[i]); end
      n_cmp++; if (err_cnt !== 2'd1) begin n_bad++; $display("FAIL jk_cnt%0d: got %0d want 1", i, err_cnt); end
    end
    n_cmp++; if (err_mask !== 8'h01) begin n_bad++; $display("FAIL jk_mask: got %h want 01", err_mask); end
    mode = 2'b11; s = 8'h0F; r = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (q !== et[i]) begin n_bad++; $display("FAIL t_toggle%0d: got %h want %h", i, q, et[i]); end
    end
  endtask

  task automatic test_d_en();
    mode = 2'b10; en = 1'b1; s = 8'h3C; r = 8'hFF;
    step();
    n_cmp++; if (q !== 8'h3C) begin n_bad++; $display("FAIL d_load: got %h want 3c", q); end
    n_cmp++; if (qbar !== 8'hC3) begin n_bad++; $display("FAIL d_qbar: got %h want c3", qbar); end
    en = 1'b0; s = 8'hC3;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (q !== 8'h3C) begin n_bad++; $display("FAIL d_en0_hold%0d: got %h want 3c", i, q); end
    end
    mode = 2'b00; s = 8'hFF; r = 8'hFF;
    step();
    n_cmp++; if (err_cnt !== 2'd1) begin n_bad++; $display("FAIL en0_masks_viol_cnt: got %0d want 1", err_cnt); end
    n_cmp++; if (err_mask !== 8'h01) begin n_bad++; $display("FAIL en0_masks_viol_mask: got %h want 01", err_mask); end
  endtask

  task automatic test_clr_sat();
    logic [WIDTH-1:0] vs [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    logic [WIDTH-1:0] em [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
    logic [CNT_W-1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    en = 1'b0; clr_err = 1'b1;
    step();
    n_cmp++; if (err_mask !== 8'h00) begin n_bad++; $display("FAIL clr_en0_mask: got %h want 00", err_mask); end
    n_cmp++; if (err_cnt !== 2'd0) begin n_bad++; $display("FAIL clr_en0_cnt: got %0d want 0", err_cnt); end
    clr_err = 1'b0; en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      s = vs[i]; r = vs[i];
      step();
      n_cmp++; if (err_cnt !== ec[i]) begin n_bad++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, err_cnt, ec[i]); end
      n_cmp++; if (err_mask !== em[i]) begin n_bad++; $display("FAIL sat_mask%0d: got %h want %h", i, err_mask, em[i]); end
    end
    n_cmp++; if (q !== 8'h3C) begin n_bad++; $display("FAIL sr_viol_hold_q: got %h want 3c", q); end
    clr_err = 1'b1; s = 8'h80; r = 8'h80;
    step();
    n_cmp++; if (err_mask !== 8'h80) begin n_bad++; $display("FAIL clr_viol_mask: got %h want 80", err_mask); end
    n_cmp++; if (err_cnt !== 2'd1) begin n_bad++; $display("FAIL clr_viol_cnt: got %0d want 1", err_cnt); end
    s = 8'h00; r = 8'h00;
    step();
    n_cmp++; if (err_mask !== 8'h00) begin n_bad++; $display("FAIL clr_mask: got %h want 00", err_mask); end
    n_cmp++; if (err_cnt !== 2'd0) begin n_bad++; $display("FAIL clr_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clr_err_flag: got %b want 0", err); end
    clr_err = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [WIDTH-1:0] et [3] = '{8'hFF, 8'h00, 8'hFF};
    en = 1'b1; mode = 2'b00; s = 8'h01; r = 8'h01;
    step();
    n_cmp++; if (err_cnt !== 2'd1) begin n_bad++; $display("FAIL pre_rst_cnt: got %0d want 1", err_cnt); end
    mode = 2'b10; s = 8'h00; r = 8'h00;
    step();
    mode = 2'b11; s = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (q !== et[i]) begin n_bad++; $display("FAIL pre_rst_toggle%0d: got %h want %h", i, q, et[i]); end
    end
    rst = 1'b1; mode = 2'b00; s = 8'hFF; r = 8'hFF;
    step();
    n_cmp++; if (q !== 8'hA5) begin n_bad++; $display("FAIL mid_rst_q: got %h want a5", q); end
    n_cmp++; if (err_cnt !== 2'd0) begin n_bad++; $display("FAIL mid_rst_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (err_mask !== 8'h00) begin n_bad++; $display("FAIL mid_rst_mask: got %h want 00", err_mask); end
    rst = 1'b0; mode = 2'b11; s = 8'hFF; r = 8'h00;
    step();
    n_cmp++; if (q !== 8'h5A) begin n_bad++; $display("FAIL post_rst_toggle: got %h want 5a", q); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; s = '0; r = '0; clr_err = 1'b0;
    #2;
    test_reset();
    test_sr();
    test_jk_t();
    test_d_en();
    test_clr_sat();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ff_bank.md
# ff_bank

Parametrised bank of WIDTH clocked flip-flop channels with a run-time selectable mode: SR, JK, D or T. It generalises the single SR flip-flop with a clock enable, a parametrised reset value and an illegal-input detector. The detector keeps a sticky per-channel violation mask and a saturating violation counter. It serves as the general-purpose state-bit primitive for control logic in the design.

## Interface
Parameters:
- WIDTH, 8, number of independent flip-flop channels (≥1)
- INIT, {WIDTH{1'b0}}, value loaded into q on reset
- CNT_W, 8, width of the violation counter (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  clock enable; when 0 all state holds
- mode  input  2  00 SR, 01 JK, 10 D, 11 T (global to all channels)
- s  input  WIDTH  per channel: S (SR), J (JK), D (D), T (T)
- r  input  WIDTH  per channel: R (SR), K (JK); ignored in D and T modes
- clr_err  input  1  clears err_mask and err_cnt
- q  output  WIDTH  state
- qbar  output  WIDTH  always ~q, combinational from the q register
- err  output  1  OR-reduction of err_mask
- err_mask  output  WIDTH  sticky: the channel has seen an SR-mode S=R=1 input
- err_cnt  output  CNT_W  number of enabled cycles with ≥1 violating channel; saturates at all-ones

## Operation
Per-channel next state when en=1 (qn = q[i]):
- SR mode: 00 → hold; 10 → 1; 01 → 0; 11 → hold, and the input counts as a violation.
- JK mode: 00 → hold; 10 → 1; 01 → 0; 11 → ~qn. This is not a violation.
- D mode: q ← s[i].
- T mode: s[i]=1 → ~qn; otherwise hold.

Violation vector v = (mode==SR) & en & s & r (bitwise).

Error state, in priority order:
- rst: err_mask ← 0, err_cnt ← 0.
- clr_err: err_mask ← v, err_cnt ← (|v ? 1 : 0). A clear and a fresh violation in the same cycle therefore keep the new event.
- Otherwise: err_mask ← err_mask | v. err_cnt increments by 1 when |v and err_cnt is not all-ones; it holds at all-ones.

Other rules:
- en=0 holds q, err_mask and err_cnt, and masks violation detection. clr_err still acts when en=0.
- A mode change takes effect on the first clock edge at which it is sampled. There is no pipeline, and the change does not disturb q.

## Timing
- All state updates on the rising edge of clk.
- Latency from inputs to q, err_mask and err_cnt: 1 cycle.
- qbar and err are combinational from registers, with no extra latency.
- Reset values:
  - q = INIT
  - qbar = ~INIT
  - err_mask = 0
  - err = 0
  - err_cnt = 0
- rst has priority over en, mode, s, r and clr_err.
- rst asserted mid-operation (for example during a T-mode toggle sequence) forces the reset values at that edge. Operation resumes on the first edge after rst deasserts.
- Saturation: with err_cnt = 2^CNT_W−1, further violations leave err_cnt unchanged; err_mask still accumulates.

## Structure
- The shared package ff_bank_pkg holds:
  - the mode constants MODE_SR=2'b00, MODE_JK=2'b01, MODE_D=2'b10, MODE_T=2'b11;
  - the mode_t 2-bit typedef.
- Sub-module ff_cell: one channel's next-state function and its violation bit.
  - Inputs: qn, s, r, mode, en.
  - Outputs: q_next, viol.
  - Instantiated WIDTH times by a generate loop.
- The top level holds the q register, the err_mask/err_cnt registers, the saturation logic and the output assignments.

## Test plan
Default parameters unless noted.
- Reset: hold rst=1 with INIT=8'hA5 and any inputs → q=8'hA5, qbar=8'h5A, err_mask=0, err_cnt=0. Then deassert rst, with en=0 for 3 cycles → q stays 8'hA5.
- SR sweep on channel 0: s/r = 10, 00, 01, 00 → q[0] = 1, 1, 0, 0. Then 11 → q[0] holds 0, err_mask=8'h01, err=1, err_cnt=1.
- JK and T: mode=JK, s=r=8'hFF for 4 cycles from q=0 → q alternates FF, 00, FF, 00 with err_cnt unchanged. Then mode=T, s=8'h0F → q toggles the low nibble only each cycle.
- D mode plus en gating: mode=D, s=8'h3C with en=1 → q=8'h3C next cycle. Then s=8'hC3 with en=0 → q stays 8'h3C.
- clr_err and saturation, with CNT_W=2: run 5 consecutive violating cycles → err_cnt sequence 1, 2, 3, 3, 3. Then assert clr_err together with s=r=8'h80 in SR mode → err_mask=8'h80, err_cnt=1. Then clr_err alone → err_mask=0, err_cnt=0, err=0.
- Reset mid-operation: in T mode toggling 8'hFF, assert rst for 1 cycle → q=INIT at that edge, and err_cnt=0 even if a violation was presented in the same cycle.
